// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, data_a, data_b,
    input  busy, done, out, bout, ovf
  );
  modport slave (
    input  start, data_a, data_b,
    output busy, done, out, bout, ovf
  );
`else
  modport master (
    output start, data_a, data_b,
    input  busy, done, out, bout
  );
  modport slave (
    input  start, data_a, data_b,
    output busy, done, out, bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB-first, registered borrow, one-cycle done.
// Optional signed overflow flag guarded by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic a0, b0, diff, bnext;

  always_comb begin
    a0    = a_sr_q[0];
    b0    = b_sr_q[0];
    diff  = a0 ^ b0 ^ borrow_q;
    bnext = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    out_d    = out_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d   = bus.data_a;
          b_sr_d   = bus.data_b;
          borrow_d = 1'b0;
          count_d  = '0;
          out_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      SHIFT: begin
        out_d    = {diff, out_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = bnext;
        count_d  = count_q + 1'b1;
        // MSB bit: publish final borrow and finish
        if (count_q == CW'(WIDTH - 1)) begin
          bout_d  = bnext;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = borrow_q ^ bnext;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      out_q    <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      out_q    <= out_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
